// File: rtl/ecg_grp_decoder.sv
// rtl/ecg_grp_decoder.sv - serial bitstream parser for one BP-mode entropy coding group
module ecg_grp_decoder #(
    parameter int SAMPLE_W = 16,
    parameter int MAX_BITS = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Data_Active,
    input  logic                  Bit_In,
    input  logic                  Bit_Valid,
    output logic                  Bit_Ready,
    output logic [4*SAMPLE_W-1:0] Samples_Out,
    output logic [3:0]            Bits_req_Out,
    output logic                  Group_Skip_Out,
    output logic                  Group_Valid,
    input  logic                  Group_Ready,
    output logic                  Proto_Err
);

    localparam int CNT_W = $clog2(4*MAX_BITS+1);

    typedef enum logic [1:0] {FLAG, PREFIX, SUFFIX, OUT} state_t;

    state_t            state, state_nxt;
    logic              ready_en;
    logic              skip_used;
    logic              xfer;
    logic [3:0]        count;
    logic [3:0]        pfx_count;
    logic [3:0]        pfx_next;
    logic              pfx_done;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  total;
    logic              suffix_last;
    logic [3:0]        samp_bit;
    logic [1:0]        samp_idx;
    logic [SAMPLE_W-1:0] cur_samp;
    logic [SAMPLE_W-1:0] new_samp;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= FLAG;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        Bit_Ready   = ready_en && (state != OUT);
        Group_Valid = (state == OUT);
        xfer        = Bit_Valid && Bit_Ready;
        // In FLAG without skip coding the bit is the first prefix bit, so the count starts at zero
        pfx_count   = (state == FLAG) ? 4'd0 : count;
        pfx_next    = pfx_count + {3'b000, Bit_In};
        pfx_done    = !Bit_In || (pfx_next == 4'(MAX_BITS));
        total       = CNT_W'({Bits_req_Out, 2'b00});
        suffix_last = (bit_cnt == total - CNT_W'(1));
        cur_samp    = '0;
        for (int i = 0; i < 4; i++) begin
            if (samp_idx == 2'(i)) begin
                cur_samp = Samples_Out[i*SAMPLE_W +: SAMPLE_W];
            end
        end
        // First bit of a sample fills every bit, so the shifted result is already sign-extended
        new_samp = (samp_bit == 4'd0) ? {SAMPLE_W{Bit_In}} : {cur_samp[SAMPLE_W-2:0], Bit_In};

        case (state)
            FLAG: begin
                if (xfer) begin
                    if (Data_Active) begin
                        state_nxt = Bit_In ? OUT : PREFIX;
                    end else if (pfx_done) begin
                        state_nxt = (pfx_next == 4'd0) ? OUT : SUFFIX;
                    end else begin
                        state_nxt = PREFIX;
                    end
                end
            end
            PREFIX: begin
                if (xfer && pfx_done) begin
                    state_nxt = (pfx_next == 4'd0) ? OUT : SUFFIX;
                end
            end
            SUFFIX: begin
                if (xfer && suffix_last) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (Group_Ready) begin
                    state_nxt = FLAG;
                end
            end
            default: state_nxt = FLAG;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ready_en       <= 1'b0;
            skip_used      <= 1'b0;
            count          <= '0;
            bit_cnt        <= '0;
            samp_bit       <= '0;
            samp_idx       <= '0;
            Samples_Out    <= '0;
            Bits_req_Out   <= '0;
            Group_Skip_Out <= 1'b0;
            Proto_Err      <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            Proto_Err <= 1'b0;
            if (xfer) begin
                case (state)
                    FLAG: begin
                        skip_used      <= Data_Active;
                        Samples_Out    <= '0;
                        Bits_req_Out   <= '0;
                        Group_Skip_Out <= Data_Active && Bit_In;
                        count          <= '0;
                        bit_cnt        <= '0;
                        samp_bit       <= '0;
                        samp_idx       <= '0;
                        if (!Data_Active) begin
                            count <= pfx_next;
                            if (pfx_done) begin
                                Bits_req_Out <= pfx_next;
                            end
                        end
                    end
                    PREFIX: begin
                        count <= pfx_next;
                        if (pfx_done) begin
                            Bits_req_Out <= pfx_next;
                            if ((pfx_next == 4'd0) && skip_used) begin
                                Proto_Err <= 1'b1;
                            end
                        end
                    end
                    SUFFIX: begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        for (int i = 0; i < 4; i++) begin
                            if (samp_idx == 2'(i)) begin
                                Samples_Out[i*SAMPLE_W +: SAMPLE_W] <= new_samp;
                            end
                        end
                        if (samp_bit == Bits_req_Out - 4'd1) begin
                            samp_bit <= '0;
                            samp_idx <= samp_idx + 2'd1;
                        end else begin
                            samp_bit <= samp_bit + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ecg_grp_decoder.md
Name: ecg_grp_decoder

Overview:
- Decoder counterpart of the BP-mode entropy coding group (ECG) encoder path.
- Consumes a serial bitstream one bit per handshake and parses one ECG:
  - an optional group skip flag;
  - a unary-coded Bits_req prefix;
  - four two's-complement suffix samples.
- Presents the four reconstructed samples as one sign-extended group on a valid/ready output.
- Sits in the decoder-side substream parser, directly downstream of the bitstream demux.

Parameters:
- SAMPLE_W, 16, output sample width in bits.
- MAX_BITS, 15, largest legal Bits_req. Must be ≤ SAMPLE_W and ≤ 15 (4-bit Bits_req_Out).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Data_Active  input  1  group skip coding enabled for this group; sampled when the first bit of a group is accepted.
- Bit_In  input  1  serial bitstream bit, MSB-first fields.
- Bit_Valid  input  1  Bit_In is valid.
- Bit_Ready  output  1  decoder accepts Bit_In this cycle.
- Samples_Out  output  4*SAMPLE_W  sample0 in bits [SAMPLE_W-1:0], through sample3 in the top slice.
- Bits_req_Out  output  4  decoded Bits_req for the group.
- Group_Skip_Out  output  1  group was coded with skip flag = 1.
- Group_Valid  output  1  output group valid.
- Group_Ready  input  1  downstream accepts the group.
- Proto_Err  output  1  one-cycle pulse on a malformed group.

Behaviour:
- Bit transfer occurs on a cycle where Bit_Valid && Bit_Ready. Non-transfer cycles change no state.
- Reset values:
  - Bit_Ready = 0, Group_Valid = 0, Proto_Err = 0.
  - Samples_Out = 0, Bits_req_Out = 0, Group_Skip_Out = 0.
  - FSM = FLAG. Bit_Ready rises the cycle after Reset deasserts.
- FSM states: FLAG, PREFIX, SUFFIX, OUT. Bit_Ready = 1 in FLAG, PREFIX and SUFFIX; 0 in OUT.
- FLAG:
  - On the first transfer of a group, latch Data_Active.
  - If Data_Active = 1, the bit is the skip flag.
    - Flag 1: set Bits_req = 0, samples = 0, Group_Skip_Out = 1, go to OUT.
    - Flag 0: go to PREFIX with count = 0.
  - If Data_Active = 0, the same bit is the first prefix bit; process it exactly as in PREFIX.
- PREFIX (unary code):
  - Each 1 bit increments count.
  - A 0 bit terminates the prefix.
  - Reaching count = MAX_BITS also terminates the prefix, with no trailing 0 consumed.
  - On termination, Bits_req = count.
    - If Bits_req = 0: samples = 0, go to OUT.
    - Otherwise: go to SUFFIX.
  - If skip was in use with flag = 0 and the decoded Bits_req = 0, pulse Proto_Err for one cycle. Still output the zero group, with Group_Skip_Out = 0.
- SUFFIX:
  - Shift in exactly 4*Bits_req bits, sample0 first, each sample MSB first.
  - Each sample is sign-extended from Bits_req bits to SAMPLE_W.
  - Bit counter width is ceil(log2(4*MAX_BITS+1)).
  - After the last bit transfer, go to OUT.
- OUT:
  - Group_Valid = 1 starting the cycle after the final bit transfer (latency 1).
  - Samples_Out, Bits_req_Out and Group_Skip_Out are stable while Group_Valid = 1.
  - Group_Valid may not drop without Group_Ready.
  - On Group_Valid && Group_Ready: Group_Valid = 0 next cycle, return to FLAG, Bit_Ready = 1 next cycle.
  - No bit is accepted while in OUT: back-pressure holds the bitstream.
- Throughput: one group per (bits consumed + 1) cycles when Group_Ready is held high.
- Reset asserted mid-group: the partial group is discarded, all state returns to reset values, and no Group_Valid is generated for it.
- Data_Active changes after the first bit of a group have no effect until the next group.
- Bit_Valid low mid-field stalls: counters hold and nothing is lost.

Test Plan:
1. Data_Active = 1, bits "1" → Group_Valid 1 cycle later; Group_Skip_Out = 1, Bits_req_Out = 0, Samples_Out = 0; 1 bit consumed.
2. Data_Active = 0, bits "110" + "01" "11" "10" "00" → Bits_req_Out = 2; samples 1, -1, -2, 0 (0x0001, 0xFFFF, 0xFFFE, 0x0000); Group_Skip_Out = 0.
3. Data_Active = 1, bits "0" "10" "1" "0" "1" "1" → Bits_req_Out = 1; samples -1, 0, -1, -1.
4. Data_Active = 0, fifteen 1s with no terminator, then 60 bits with sample0 = 0x4000 pattern (15 bits "100000000000000") and others 0x3FFF → Bits_req_Out = 15; sample0 = 0xC000, samples 1–3 = 0x3FFF.
5. Hold Group_Ready = 0 for 5 cycles with Bit_Valid = 1 → Bit_Ready = 0 and outputs stable throughout; the next group decodes correctly after acceptance. Separately, Data_Active = 1 with bits "0" "0" → single Proto_Err pulse plus a zero group with Group_Skip_Out = 0.
6. Assert Reset after 3 suffix bits → no Group_Valid; all outputs at reset values. The following group "1" (Data_Active = 1) decodes as a skip group.
